rpn_calc_core: RTL and testbench
================================

RPN_CALC_CORE -- requirements
Module: rpn_calc_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8: operand, result and stack-entry width (>=4).
REQ-002 SHALL have parameter DEPTH, default 8: operand-stack entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a new expression; sampled in IDLE only.
REQ-006 SHALL have port tok_valid  input  1  token present.
REQ-007 SHALL have port tok_ready  output  1  core accepts token this cycle.
REQ-008 SHALL have port tok_is_op  input  1  1=operator, 0=operand.
REQ-009 SHALL have port tok_data  input  DATA_W  operand value, or opcode in [2:0]: 0 add, 1 sub, 2 mul, 3 div, 4 end ('#'); 5-7 illegal.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when evaluation ends.
REQ-012 SHALL have port result  output  DATA_W  final value, held until next start.
REQ-013 SHALL have port err  output  3  sticky flags {div_zero, underflow, overflow_or_illegal}, held until next start.

Function
REQ-014 SHALL implement states IDLE, FETCH, EXEC, DIV, FINISH, FAIL.
REQ-015 IDLE: start=1 -> clear stack count, result, err; go FETCH next cycle. start in any other state SHALL be ignored.
REQ-016 FETCH: tok_ready=1; transfer only when tok_valid&&tok_ready; tok_ready=0 in all other states.
REQ-017 Operand transfer: push tok_data; stay FETCH. Push at count==DEPTH -> set err[0], go FAIL.
REQ-018 Arithmetic operator (0-3) with count<2 -> set err[1], go FAIL; otherwise go EXEC (opcodes 0-2) or DIV (opcode 3).
REQ-019 Operands: A = entry below top, B = top; result pushed replaces both (count decrements by 1).
REQ-020 EXEC: one cycle; A+B, A-B, A*B truncated modulo 2^DATA_W (unsigned, low DATA_W bits of product); return to FETCH.
REQ-021 DIV: B==0 -> set err[2], go FAIL on next cycle; otherwise iterative restoring division, exactly DATA_W cycles in DIV, unsigned quotient A/B pushed, then FETCH.
REQ-022 End opcode 4: count==1 -> result=top, go FINISH; count!=1 -> set err[1], go FAIL.
REQ-023 Opcode 5-7 -> set err[0], go FAIL.
REQ-024 FINISH and FAIL: done=1 for exactly one cycle, then IDLE; FAIL forces result=0.
REQ-025 Token-to-token throughput: one operand per cycle; operator latency 1 cycle (EXEC) or DATA_W+1 cycles (DIV) before tok_ready reasserts.
REQ-026 tok_valid while tok_ready=0 SHALL not be consumed; upstream holds token.

Reset
REQ-027 rst=1 at any time, including mid-DIV, SHALL force IDLE, stack count 0, tok_ready=0, busy=0, done=0, result=0, err=0 immediately (asynchronous).
REQ-028 Stack storage contents SHALL not need reset; only count/pointer is reset.

Configuration
REQ-029 With macro RPN_CALC_DIV_EN defined: DIV state and divider compiled in, opcode 3 per REQ-021.
REQ-030 Without RPN_CALC_DIV_EN: no divider logic; opcode 3 treated as illegal per REQ-023.

Verification
REQ-031 DATA_W=8: start; 3,4,+,2,*,# -> done one cycle, result=14, err=000.
REQ-032 3,5,-,# -> result=254 (wrap); 200,2,*,# -> result=144 (truncate).
REQ-033 DIV_EN: 7,0,/ -> err=100, result=0, done; 200,7,/,# -> result=28, tok_ready low exactly 9 cycles after '/' accept.
REQ-034 + as first token -> err=010; 3,4,# -> err=010; DEPTH+1 operands -> err=001, done.
REQ-035 rst asserted mid-DIV -> busy=0, done=0, result=0 same cycle; next start runs cleanly.
REQ-036 Without DIV_EN: 8,2,/ -> err=001, done; tok_valid held during EXEC not consumed twice.

Source files
------------

// File: rtl/rpn_calc_core.sv
// rpn_calc_core: token-driven RPN evaluator with an operand stack and registered outputs.
// Define RPN_CALC_DIV_EN to build the iterative divider (opcode 3); otherwise opcode 3 is illegal.
module rpn_calc_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic              tok_is_op,
  input  logic [DATA_W-1:0] tok_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_END = 3'd4;

`ifdef RPN_CALC_DIV_EN
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam int unsigned DIV_CNT_W = $clog2(DATA_W);
`endif

  logic [2:0]        state, state_d;
  logic [CNT_W-1:0]  count, count_d;
  logic [DATA_W-1:0] a_r, a_d, b_r, b_d;
  logic [1:0]        op_r, op_d;
  logic [DATA_W-1:0] result_d;
  logic [2:0]        err_d;
  logic              done_d, busy_d, ready_d;
  logic [DATA_W-1:0] top, below, alu;
  logic              push_en;
  logic [IDX_W-1:0]  push_idx;
  logic [DATA_W-1:0] push_val;

  logic [DATA_W-1:0] stack [DEPTH];

`ifdef RPN_CALC_DIV_EN
  logic [DATA_W-1:0]    quo, quo_d, rem, rem_d;
  logic [DIV_CNT_W-1:0] div_cnt, div_cnt_d;
  logic [DATA_W:0]      shift, diff;
`endif

  assign top   = stack[IDX_W'(count - CNT_W'(1))];
  assign below = stack[IDX_W'(count - CNT_W'(2))];

  // Write-back value for the operator captured at accept time
  always_comb begin
    alu = '0;
    case (op_r)
      2'd0:    alu = a_r + b_r;
      2'd1:    alu = a_r - b_r;
      2'd2:    alu = a_r * b_r;
`ifdef RPN_CALC_DIV_EN
      default: alu = quo;
`else
      default: alu = '0;
`endif
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state;
    count_d  = count;
    a_d      = a_r;
    b_d      = b_r;
    op_d     = op_r;
    result_d = result;
    err_d    = err;
    push_en  = 1'b0;
    push_idx = IDX_W'(count);
    push_val = tok_data;
`ifdef RPN_CALC_DIV_EN
    quo_d     = quo;
    rem_d     = rem;
    div_cnt_d = div_cnt;
    shift     = {rem, quo[DATA_W-1]};
    diff      = shift - {1'b0, b_r};
`endif

    case (state)
      S_IDLE: begin
        if (start) begin
          count_d  = '0;
          result_d = '0;
          err_d    = '0;
          state_d  = S_FETCH;
        end
      end

      S_FETCH: begin
        if (tok_valid && tok_ready) begin
          if (!tok_is_op) begin
            if (count == CNT_W'(DEPTH)) begin
              err_d[0] = 1'b1;
              state_d  = S_FAIL;
            end else begin
              push_en = 1'b1;
              count_d = count + CNT_W'(1);
            end
          end else begin
            case (tok_data[2:0])
              OP_ADD, OP_SUB, OP_MUL: begin
                if (count < CNT_W'(2)) begin
                  err_d[1] = 1'b1;
                  state_d  = S_FAIL;
                end else begin
                  a_d     = below;
                  b_d     = top;
                  op_d    = tok_data[1:0];
                  state_d = S_EXEC;
                end
              end
`ifdef RPN_CALC_DIV_EN
              OP_DIV: begin
                if (count < CNT_W'(2)) begin
                  err_d[1] = 1'b1;
                  state_d  = S_FAIL;
                end else begin
                  b_d       = top;
                  quo_d     = below;
                  rem_d     = '0;
                  div_cnt_d = '0;
                  op_d      = 2'd3;
                  state_d   = S_DIV;
                end
              end
`endif
              OP_END: begin
                if (count == CNT_W'(1)) begin
                  result_d = top;
                  state_d  = S_FINISH;
                end else begin
                  err_d[1] = 1'b1;
                  state_d  = S_FAIL;
                end
              end
              default: begin
                err_d[0] = 1'b1;
                state_d  = S_FAIL;
              end
            endcase
          end
        end
      end

      // Pop two, push one: result lands where operand A sat
      S_EXEC: begin
        push_en  = 1'b1;
        push_idx = IDX_W'(count - CNT_W'(2));
        push_val = alu;
        count_d  = count - CNT_W'(1);
        state_d  = S_FETCH;
      end

`ifdef RPN_CALC_DIV_EN
      // One restoring step per cycle; quotient bits shift in from the right
      S_DIV: begin
        if (b_r == '0) begin
          err_d[2] = 1'b1;
          state_d  = S_FAIL;
        end else begin
          if (!diff[DATA_W]) begin
            rem_d = diff[DATA_W-1:0];
            quo_d = {quo[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = shift[DATA_W-1:0];
            quo_d = {quo[DATA_W-2:0], 1'b0};
          end
          div_cnt_d = div_cnt + DIV_CNT_W'(1);
          if (div_cnt == DIV_CNT_W'(DATA_W - 1)) state_d = S_EXEC;
        end
      end
`endif

      S_FINISH: state_d = S_IDLE;
      S_FAIL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (state_d == S_FAIL) result_d = '0;
    done_d  = (state_d == S_FINISH) || (state_d == S_FAIL);
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_FETCH);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= '0;
      result    <= '0;
      err       <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      tok_ready <= 1'b0;
`ifdef RPN_CALC_DIV_EN
      quo       <= '0;
      rem       <= '0;
      div_cnt   <= '0;
`endif
    end else begin
      state     <= state_d;
      count     <= count_d;
      a_r       <= a_d;
      b_r       <= b_d;
      op_r      <= op_d;
      result    <= result_d;
      err       <= err_d;
      done      <= done_d;
      busy      <= busy_d;
      tok_ready <= ready_d;
`ifdef RPN_CALC_DIV_EN
      quo       <= quo_d;
      rem       <= rem_d;
      div_cnt   <= div_cnt_d;
`endif
    end
  end

  // Stack storage needs no reset; count alone defines validity
  always_ff @(posedge clk) begin
    if (push_en) stack[push_idx] <= push_val;
  end

endmodule

// File: tb/tb_rpn_calc_core.sv
// Self-checking bench for rpn_calc_core: directed table, reset corner cases and random
// expressions checked against a queue-based RPN evaluator.
module tb_rpn_calc_core;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int MAXT   = 20;
`ifdef RPN_CALC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef logic [MAXT-1:0][8:0] tokv_t;
  typedef struct packed {
    tokv_t       tok;
    logic [4:0]  n;
    logic [7:0]  res;
    logic [2:0]  err;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              tok_valid = 1'b0;
  logic              tok_ready;
  logic              tok_is_op = 1'b0;
  logic [DATA_W-1:0] tok_data = '0;
  logic              busy, done;
  logic [DATA_W-1:0] result;
  logic [2:0]        err;

  int checks = 0;
  int errors = 0;
  int gap [MAXT];

  rpn_calc_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_is_op(tok_is_op), .tok_data(tok_data), .busy(busy), .done(done),
    .result(result), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, want %0d", name, idx, act, exp);
    end
  endtask

  // Tokens written as text: numbers are operands, + - * / # are opcodes 0-4, ? and ! are 5 and 7
  function automatic vec_t mk(input string s, input int r, input int e);
    vec_t v;
    int val, n;
    bit innum;
    byte c;
    v = '0; val = 0; n = 0; innum = 0;
    for (int i = 0; i <= s.len(); i++) begin
      c = (i < s.len()) ? s.getc(i) : " ";
      if (c >= "0" && c <= "9") begin
        val = val * 10 + int'(c - "0");
        innum = 1;
      end else begin
        if (innum) begin
          v.tok[n] = {1'b0, 8'(val)};
          n++; val = 0; innum = 0;
        end
        case (c)
          "+": begin v.tok[n] = {1'b1, 8'd0}; n++; end
          "-": begin v.tok[n] = {1'b1, 8'd1}; n++; end
          "*": begin v.tok[n] = {1'b1, 8'd2}; n++; end
          "/": begin v.tok[n] = {1'b1, 8'd3}; n++; end
          "#": begin v.tok[n] = {1'b1, 8'd4}; n++; end
          "?": begin v.tok[n] = {1'b1, 8'd5}; n++; end
          "!": begin v.tok[n] = {1'b1, 8'd7}; n++; end
          default: ;
        endcase
      end
    end
    v.n   = 5'(n);
    v.res = 8'(r);
    v.err = 3'(e);
    return v;
  endfunction

  // Reference evaluator: plain integer stack, stops at the first terminating token
  function automatic void model(input tokv_t t, input int n, output int res, output int e, output int used);
    int st[$];
    int a, b, r;
    int opc;
    bit stop;
    res = 0; e = 0; used = n; stop = 0;
    for (int i = 0; i < n && !stop; i++) begin
      used = i + 1;
      if (!t[i][8]) begin
        if (st.size() == DEPTH) begin e = 1; stop = 1; end
        else st.push_back(int'(t[i][7:0]));
      end else begin
        opc = int'(t[i][2:0]);
        if (opc <= 2 || (opc == 3 && DIV_EN)) begin
          if (st.size() < 2) begin e = 2; stop = 1; end
          else begin
            b = st.pop_back();
            a = st.pop_back();
            case (opc)
              0: r = a + b;
              1: r = a - b;
              2: r = a * b;
              default: r = (b == 0) ? 0 : a / b;
            endcase
            if (opc == 3 && b == 0) begin e = 4; stop = 1; end
            else st.push_back(r & ((1 << DATA_W) - 1));
          end
        end else if (opc == 4) begin
          if (st.size() == 1) res = st[0];
          else e = 2;
          stop = 1;
        end else begin
          e = 1; stop = 1;
        end
      end
    end
  endfunction

  // Drives one expression; tokens stay presented while tok_ready is low
  task automatic run(input tokv_t t, input int n, input bit rnd, output int r, output int e,
                     output int used, output bit got);
    int idx, cur_op;
    bit xfer;
    idx = 0; cur_op = -1; xfer = 0; got = 0; r = 0; e = 0;
    for (int j = 0; j < MAXT; j++) gap[j] = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_ready_after_start", n, {busy, tok_ready}, 2'b11);
    for (int cyc = 0; cyc < 400 && !got; cyc++) begin
      if (xfer) begin
        cur_op = t[idx][8] ? idx : -1;
        idx++;
        xfer = 0;
      end
      if (cur_op >= 0) begin
        if (!tok_ready) gap[cur_op]++;
        else cur_op = -1;
      end
      if (done) begin
        got = 1; r = int'(result); e = int'(err);
        tok_valid = 1'b0;
        start = 1'b0;
      end else begin
        if (idx < n && !(rnd && $urandom_range(0, 3) == 0)) begin
          tok_valid = 1'b1;
          tok_is_op = t[idx][8];
          tok_data  = t[idx][7:0];
          xfer      = tok_ready;
        end else begin
          tok_valid = 1'b0;
        end
        start = rnd && ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
    end
    tok_valid = 1'b0;
    start = 1'b0;
    used = idx;
  endtask

  task automatic check_expr(input string tag, input int vi, input tokv_t t, input int n,
                            input int er, input int ee, input bit rnd);
    int mr, me, mu, r, e, used;
    bit got;
    model(t, n, mr, me, mu);
    run(t, n, rnd, r, e, used, got);
    chk({tag, "_done_seen"}, vi, got, 1);
    if (got) begin
      chk({tag, "_result"}, vi, r, er);
      chk({tag, "_err"}, vi, e, ee);
      chk({tag, "_tokens_used"}, vi, used, mu);
      for (int j = 0; j < mu - 1; j++)
        if (t[j][8] && t[j][2:0] <= 3'd3)
          chk({tag, "_ready_gap"}, vi * 100 + j, gap[j], (t[j][2:0] == 3'd3) ? DATA_W + 1 : 1);
      @(negedge clk);
      chk({tag, "_done_pulse_busy"}, vi, {done, busy}, 2'b00);
      chk({tag, "_result_hold"}, vi, int'(result), er);
    end
  endtask

  task automatic send_tok(input bit is_op, input int d);
    for (int k = 0; k < 50 && !tok_ready; k++) @(negedge clk);
    chk("send_ready", d, tok_ready, 1);
    tok_valid = 1'b1;
    tok_is_op = is_op;
    tok_data  = 8'(d);
    @(negedge clk);
    tok_valid = 1'b0;
  endtask

  initial begin
    vec_t  vecs [15];
    tokv_t rt;
    int    rn, mr, me, mu, len, sel;

    vecs[0]  = mk("3 4 + 2 * #", 14, 3'b000);
    vecs[1]  = mk("3 5 - #", 254, 3'b000);
    vecs[2]  = mk("200 2 * #", 144, 3'b000);
    vecs[3]  = mk("+", 0, 3'b010);
    vecs[4]  = mk("3 4 #", 0, 3'b010);
    vecs[5]  = mk("1 2 3 4 5 6 7 8 9", 0, 3'b001);
`ifdef RPN_CALC_DIV_EN
    vecs[6]  = mk("8 2 / #", 4, 3'b000);
    vecs[7]  = mk("7 0 / #", 0, 3'b100);
    vecs[8]  = mk("200 7 / #", 28, 3'b000);
`else
    vecs[6]  = mk("8 2 / #", 0, 3'b001);
    vecs[7]  = mk("7 0 / #", 0, 3'b001);
    vecs[8]  = mk("200 7 / #", 0, 3'b001);
`endif
    vecs[9]  = mk("5 ?", 0, 3'b001);
    vecs[10] = mk("#", 0, 3'b010);
    vecs[11] = mk("9 #", 9, 3'b000);
    vecs[12] = mk("255 255 * #", 1, 3'b000);
    vecs[13] = mk("1 2 3 4 5 6 7 8 + + + + + + + #", 36, 3'b000);
    vecs[14] = mk("10 3 - 4 * 6 !", 0, 3'b001);

    // Reset values while rst is held from time zero
    @(negedge clk);
    chk("reset_outputs", 0, {tok_ready, busy, done, result, err}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 0, {tok_ready, busy, done}, 3'b000);

    for (int i = 0; i < 15; i++)
      check_expr("vec", i, vecs[i].tok, int'(vecs[i].n), int'(vecs[i].res), int'(vecs[i].err), 1'b0);

    // Asynchronous reset in the middle of an operator (DIV when built with the divider)
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_tok(1'b0, 200);
    send_tok(1'b0, 7);
    send_tok(1'b1, DIV_EN ? 3 : 0);
    repeat (3) @(negedge clk);
    chk("busy_before_rst", 0, busy, 1);
    #2 rst = 1'b1;
    #1 chk("rst_mid_op", 0, {tok_ready, busy, done, result, err}, '0);
    @(negedge clk);
    rst = 1'b0;
    check_expr("post_rst", 0, vecs[0].tok, int'(vecs[0].n), 14, 0, 1'b0);

    // Random expressions with bubbles and stray start pulses
    for (int i = 0; i < 60; i++) begin
      rt = '0;
      rn = 0;
      len = $urandom_range(1, 15);
      for (int k = 0; k < len; k++) begin
        sel = $urandom_range(0, 99);
        if (sel < 55)
          rt[rn] = {1'b0, 8'((sel < 10) ? $urandom_range(0, 3) : $urandom_range(0, 255))};
        else if (sel < 92)
          rt[rn] = {1'b1, 8'($urandom_range(0, 3))};
        else if (sel < 96)
          rt[rn] = {1'b1, 8'd4};
        else
          rt[rn] = {1'b1, 8'($urandom_range(5, 7))};
        rn++;
      end
      rt[rn] = {1'b1, 8'd4};
      rn++;
      model(rt, rn, mr, me, mu);
      check_expr("rand", i, rt, rn, mr, me, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
